pend_dec32_5: RTL and testbench



---
 rtl/pend_dec32_5_pkg.sv | 21 ++
 rtl/pend_dec32_5_dec5_32.sv | 25 ++
 rtl/pend_dec32_5.sv | 110 +++++++++++
 tb/tb_pend_dec32_5.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pend_dec32_5_pkg.sv
// ---------------------------------------------------------------------------
// pend_dec32_5_pkg
// Shared constants for the pending-request tracker and its one-hot decoder.
//   IDXW     : width of a request index
//   WIDTH    : width of the request vector (2**IDXW)
//   CNTW     : width of the occupancy counter (holds 0..WIDTH)
//   FULL_VEC : every request pending
//   ZERO_VEC : no request pending
//   FULL_CNT : counter value that means every bit is pending
// ---------------------------------------------------------------------------
package pend_dec32_5_pkg;

  localparam int IDXW  = 5;
  localparam int WIDTH = 32;
  localparam int CNTW  = IDXW + 1;

  localparam logic [WIDTH-1:0] FULL_VEC = '1;
  localparam logic [WIDTH-1:0] ZERO_VEC = '0;
  localparam logic [CNTW-1:0]  FULL_CNT = CNTW'(WIDTH);

endpackage

// File: rtl/pend_dec32_5_dec5_32.sv
// ---------------------------------------------------------------------------
// dec5_32
// Combinational index-to-one-hot decoder with enable; the inverse of the
// per32_5 priority encoder.
//   en_i  : decode enable; output is all zeros when low
//   idx_i : index to decode
//   oh_o  : one-hot vector with bit idx_i set when enabled
// ---------------------------------------------------------------------------
module dec5_32
  import pend_dec32_5_pkg::*;
(
  input  logic            en_i,
  input  logic [IDXW-1:0] idx_i,
  output logic [WIDTH-1:0] oh_o
);

  // A disabled decoder contributes nothing, so callers can OR/mask freely.
  always_comb begin
    oh_o = ZERO_VEC;
    if (en_i) begin
      oh_o = WIDTH'(1) << idx_i;
    end
  end

endmodule

// File: rtl/pend_dec32_5.sv
// ---------------------------------------------------------------------------
// pend_dec32_5
// Pending-request tracker feeding the per32_5 priority encoder. Set indices
// are decoded and accumulated in a pending vector; the serviced index coming
// back from the encoder clears its bit. All outputs are registered.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   set_idx : index of request to mark pending, qualified by set_v
//   clr_idx : index of serviced request, qualified by clr_v
//   flush   : synchronous clear of all pending state (beats set and clear)
//   pend    : pending vector
//   set_oh  : one-hot of the set accepted on the previous cycle, else 0
//   count   : number of pending bits (0..WIDTH)
//   empty   : no bit pending
//   full    : every bit pending
//   dup     : one-cycle pulse, a set landed on an already-pending bit
// ---------------------------------------------------------------------------
module pend_dec32_5
  import pend_dec32_5_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDXW-1:0]  set_idx,
  input  logic             set_v,
  input  logic [IDXW-1:0]  clr_idx,
  input  logic             clr_v,
  input  logic             flush,
  output logic [WIDTH-1:0] pend,
  output logic [WIDTH-1:0] set_oh,
  output logic [CNTW-1:0]  count,
  output logic             empty,
  output logic             full,
  output logic             dup
);

  logic [WIDTH-1:0] setVec;
  logic [WIDTH-1:0] clrVec;

  logic [WIDTH-1:0] pend_q,   pend_d;
  logic [WIDTH-1:0] set_oh_q, set_oh_d;
  logic [CNTW-1:0]  count_q,  count_d;
  logic             empty_q,  empty_d;
  logic             full_q,   full_d;
  logic             dup_q,    dup_d;

  logic sameIdx;
  logic inc;
  logic dec;

  dec5_32 u_setDec (
    .en_i  (set_v),
    .idx_i (set_idx),
    .oh_o  (setVec)
  );

  dec5_32 u_clrDec (
    .en_i  (clr_v),
    .idx_i (clr_idx),
    .oh_o  (clrVec)
  );

  // Next-state logic. The counter is kept incrementally rather than by a
  // popcount: a set only counts when its bit was idle, a clear only counts
  // when its bit was pending and is not being re-set in the same cycle.
  // The flags are taken from the next count so they line up with pend.
  always_comb begin
    sameIdx  = (set_idx == clr_idx);
    inc      = set_v & ~pend_q[set_idx] & ~flush;
    dec      = clr_v & pend_q[clr_idx] & ~(set_v & sameIdx) & ~flush;
    pend_d   = ZERO_VEC;
    set_oh_d = ZERO_VEC;
    count_d  = '0;
    dup_d    = 1'b0;
    if (!flush) begin
      pend_d   = (pend_q & ~clrVec) | setVec;
      set_oh_d = setVec;
      count_d  = count_q + CNTW'(inc) - CNTW'(dec);
      dup_d    = set_v & pend_q[set_idx] & ~(clr_v & sameIdx);
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_CNT);
  end

  // State registers; reset leaves the tracker empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q   <= ZERO_VEC;
      set_oh_q <= ZERO_VEC;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      dup_q    <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      set_oh_q <= set_oh_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      dup_q    <= dup_d;
    end
  end

  assign pend   = pend_q;
  assign set_oh = set_oh_q;
  assign count  = count_q;
  assign empty  = empty_q;
  assign full   = full_q;
  assign dup    = dup_q;

endmodule

// File: tb/tb_pend_dec32_5.sv
// ---------------------------------------------------------------------------
// tb_pend_dec32_5
// Directed and random stimulus for pend_dec32_5, checked against a
// set-of-requests model: the model keeps the pending set as a plain bit
// array and derives count/empty/full from it directly.
// ---------------------------------------------------------------------------
module tb_pend_dec32_5;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  set_idx;
  logic        set_v;
  logic [4:0]  clr_idx;
  logic        clr_v;
  logic        flush;
  logic [31:0] pend;
  logic [31:0] set_oh;
  logic [5:0]  count;
  logic        empty;
  logic        full;
  logic        dup;

  int errors = 0;
  int checks = 0;

  logic [31:0] mPend;
  logic [31:0] mSetOh;
  logic        mDup;

  pend_dec32_5 dut (
    .clk     (clk),
    .rst     (rst),
    .set_idx (set_idx),
    .set_v   (set_v),
    .clr_idx (clr_idx),
    .clr_v   (clr_v),
    .flush   (flush),
    .pend    (pend),
    .set_oh  (set_oh),
    .count   (count),
    .empty   (empty),
    .full    (full),
    .dup     (dup)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // One comparison with its failure report.
  task automatic chk(input string where, input string tag,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s %s: observed=%h expected=%h", where, tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model by the request-set rules,
  // then step past the clock edge so outputs can be sampled.
  task automatic applyStimulus(input logic sv, input logic [4:0] si,
                               input logic cv, input logic [4:0] ci,
                               input logic fl);
    set_v   = sv;
    set_idx = si;
    clr_v   = cv;
    clr_idx = ci;
    flush   = fl;
    if (fl) begin
      mPend  = '0;
      mSetOh = '0;
      mDup   = 1'b0;
    end else begin
      mDup = sv && mPend[si] && !(cv && ci == si);
      if (cv) mPend[ci] = 1'b0;
      if (sv) mPend[si] = 1'b1;
      mSetOh = sv ? (32'd1 << si) : 32'd0;
    end
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the model.
  task automatic checkOutput(input string where);
    chk(where, "pend",   pend,   mPend);
    chk(where, "set_oh", set_oh, mSetOh);
    chk(where, "count",  {26'd0, count}, $countones(mPend));
    chk(where, "empty",  {31'd0, empty}, {31'd0, mPend == 32'd0});
    chk(where, "full",   {31'd0, full},  {31'd0, &mPend});
    chk(where, "dup",    {31'd0, dup},   {31'd0, mDup});
  endtask

  // Directed scenarios followed by a random soak.
  initial begin
    logic [4:0] encIdx;
    logic       encV;
    int         drainCycle;

    rst = 1'b1; set_v = 0; set_idx = 0; clr_v = 0; clr_idx = 0; flush = 0;
    mPend = '0; mSetOh = '0; mDup = 1'b0;
    #1;
    checkOutput("reset");
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset in the middle of a run with bits 4..7 pending.
    for (int i = 4; i < 8; i++) applyStimulus(1, 5'(i), 0, 0, 0);
    checkOutput("preReset");
    #2;
    rst = 1'b1;
    #1;
    mPend = '0; mSetOh = '0; mDup = 1'b0;
    checkOutput("asyncReset");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 5'd3, 0, 0, 0);
    checkOutput("afterRelease");
    chk("afterRelease", "pendConst", pend, 32'h0000_0008);

    // Fill every index, then a duplicate set at full.
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1, 5'(i), 0, 0, 0);
      checkOutput("fill");
    end
    chk("fill", "fullVec", pend, 32'hFFFF_FFFF);
    applyStimulus(1, 5'd7, 0, 0, 0);
    checkOutput("dupAtFull");
    chk("dupAtFull", "dupConst", {31'd0, dup}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("dupPulseEnds");

    // Set at full plus clear of a different bit leaves 31 pending.
    applyStimulus(1, 5'd2, 1, 5'd9, 0);
    checkOutput("fullSetClr");
    chk("fullSetClr", "count31", {26'd0, count}, 32'd31);

    // Same-index set and clear: set wins, no dup.
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 5'd29, 0, 0, 0);
    applyStimulus(1, 5'd29, 1, 5'd29, 0);
    checkOutput("collision");
    chk("collision", "pendConst", pend, 32'h2000_0000);

    // Flush beats a simultaneous set.
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 8; i < 24; i++) applyStimulus(1, 5'(i), 0, 0, 0);
    chk("flushPrep", "pendConst", pend, 32'h00FF_FF00);
    applyStimulus(1, 5'd0, 0, 0, 1);
    checkOutput("flushPrio");

    // Clearing an idle bit changes nothing.
    for (int i = 0; i < 8; i++) applyStimulus(1, 5'(i), 0, 0, 0);
    applyStimulus(0, 0, 1, 5'd31, 0);
    checkOutput("spuriousClr");
    chk("spuriousClr", "count8", {26'd0, count}, 32'd8);

    // Closed loop with a lowest-index-first encoder retiring one bit a cycle.
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) applyStimulus(1, 5'(i), 0, 0, 0);
    chk("loopLoad", "pendConst", pend, 32'h0000_FFFF);
    drainCycle = -1;
    for (int k = 1; k <= 20; k++) begin
      encV = |pend;
      encIdx = '0;
      for (int b = 31; b >= 0; b--) if (pend[b]) encIdx = 5'(b);
      applyStimulus(0, 0, encV, encIdx, 0);
      checkOutput("closedLoop");
      chk("closedLoop", "encV", {31'd0, |pend}, {31'd0, mPend != 32'd0});
      if (empty && drainCycle < 0) drainCycle = k;
    end
    chk("closedLoop", "drainCycles", drainCycle, 32'd16);

    // Random soak, sets biased above clears, occasional flush.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 1) != 0), 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 40) == 0));
      checkOutput("soak");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
